// File: rtl/dca_matrix_row_loader_if.sv
// Row-in / matrix-write-out bundle between a row source, the loader and the matrix register.
// Latency: none (wires only).
// Backpressure: row_valid/row_ready on the row side; all_wenable is held until commit_ready.
interface dca_matrix_row_loader_if #(
  parameter int BW_ROW    = 256,
  parameter int BW_MATRIX = 2048,
  parameter int BW_COUNT  = 4
);
  logic                 row_valid;
  logic                 row_ready;
  logic [BW_ROW-1:0]    row_data;
  logic                 row_last;
  logic                 all_wenable;
  logic [BW_MATRIX-1:0] all_wdata_list2d;
  logic                 commit_ready;
  logic [BW_COUNT-1:0]  loaded_count;

  // Loader side: consumes rows, produces the held matrix write request.
  modport master (
    input  row_valid, row_data, row_last, commit_ready,
    output row_ready, all_wenable, all_wdata_list2d, loaded_count
  );

  // Environment side: row producer plus matrix register acceptor.
  modport slave (
    output row_valid, row_data, row_last, commit_ready,
    input  row_ready, all_wenable, all_wdata_list2d, loaded_count
  );
endinterface

// File: rtl/dca_matrix_row_loader.sv
// Purpose: assembles matrix rows, one per beat, and presents the whole matrix as a held write.
// Latency: last row accepted in cycle N -> all_wenable in cycle N+1; next row no earlier than N+2.
// Backpressure: row_ready drops while the write is pending; all_wenable holds until commit_ready.
// Optional build macro DCA_ROW_LOADER_COLUMN_MODE_EN adds column_mode (beat k fills column k).
module dca_matrix_row_loader #(
  parameter int                          MATRIX_SIZE_PARA = 8,
  parameter int                          BW_TENSOR_SCALAR = 32,
  parameter logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE      = '0,
  parameter logic [BW_TENSOR_SCALAR-1:0] INIT_VALUE       = RESET_VALUE
) (
  input  logic clk,
  input  logic rstnn,
  input  logic init,
`ifdef DCA_ROW_LOADER_COLUMN_MODE_EN
  input  logic column_mode,
`endif
  dca_matrix_row_loader_if.master bus
);

  // Geometry code is square: the size code gives both row and column counts.
  localparam int MATRIX_NUM_ROW   = MATRIX_SIZE_PARA;
  localparam int MATRIX_NUM_COL   = MATRIX_SIZE_PARA;
  localparam int BW_TENSOR_ROW    = MATRIX_NUM_COL * BW_TENSOR_SCALAR;
  localparam int BW_TENSOR_MATRIX = MATRIX_NUM_ROW * BW_TENSOR_ROW;
  localparam int NUM_ELEM         = MATRIX_NUM_ROW * MATRIX_NUM_COL;
  localparam int CW               = $clog2(MATRIX_NUM_ROW + 1);

  typedef enum logic {FILL, COMMIT} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               count_q;
  logic [BW_TENSOR_MATRIX-1:0] mat_q;
  logic                        xfer;
  logic                        accept;

`ifdef DCA_ROW_LOADER_COLUMN_MODE_EN
  logic col_mode_q;
  logic col_mode_eff;

  if (MATRIX_NUM_ROW != MATRIX_NUM_COL) begin : g_geom_check
    $error("column mode needs a square matrix");
  end

  // Mode is taken live on the first beat of a matrix, then from the latch.
  assign col_mode_eff = (count_q == '0) ? column_mode : col_mode_q;
`endif

  // Next-state and handshake decode; init overrides everything and drops any offered row.
  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      FILL: begin
        xfer = bus.row_valid;
        if (xfer && (count_q == CW'(MATRIX_NUM_ROW - 1) || bus.row_last)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        accept = bus.commit_ready;
        if (accept) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (init) begin
      state_d = FILL;
      xfer    = 1'b0;
      accept  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Row buffer and fill counter; cleared to INIT_VALUE on init and on every accepted commit.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      count_q <= '0;
      mat_q   <= {NUM_ELEM{RESET_VALUE}};
    end else if (init || accept) begin
      count_q <= '0;
      mat_q   <= {NUM_ELEM{INIT_VALUE}};
    end else if (xfer) begin
      count_q <= count_q + CW'(1);
      for (int r = 0; r < MATRIX_NUM_ROW; r++) begin
`ifdef DCA_ROW_LOADER_COLUMN_MODE_EN
        if (col_mode_eff) begin
          for (int k = 0; k < MATRIX_NUM_COL; k++) begin
            if (count_q == CW'(k)) begin
              mat_q[r*BW_TENSOR_ROW + k*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR]
                <= bus.row_data[r*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR];
            end
          end
        end else if (count_q == CW'(r)) begin
          mat_q[r*BW_TENSOR_ROW +: BW_TENSOR_ROW] <= bus.row_data;
        end
`else
        if (count_q == CW'(r)) begin
          mat_q[r*BW_TENSOR_ROW +: BW_TENSOR_ROW] <= bus.row_data;
        end
`endif
      end
    end
  end

`ifdef DCA_ROW_LOADER_COLUMN_MODE_EN
  // Column-mode latch, captured on the first beat and held through the pending write.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      col_mode_q <= 1'b0;
    end else if (init || accept) begin
      col_mode_q <= 1'b0;
    end else if (xfer && count_q == '0) begin
      col_mode_q <= column_mode;
    end
  end
`endif

  assign bus.row_ready        = (state_q == FILL);
  assign bus.all_wenable      = (state_q == COMMIT);
  assign bus.all_wdata_list2d = mat_q;
  assign bus.loaded_count     = count_q;

endmodule

// File: tb/tb_dca_matrix_row_loader.sv
// Bench for dca_matrix_row_loader: table of load cases plus hand sequences for stall, abort, reset.
// Latency: checks all_wenable exactly one cycle after the last accepted row.
// Backpressure: exercises commit_ready low while row_valid stays high.
module tb_dca_matrix_row_loader;
  localparam int ROWS  = 8;
  localparam int SC    = 32;
  localparam int BW_R  = ROWS * SC;
  localparam int BW_M  = ROWS * BW_R;
  localparam int CW    = $clog2(ROWS + 1);
  localparam logic [SC-1:0] RST_V  = 32'h0;
  localparam logic [SC-1:0] INIT_V = 32'hDEAD;

  logic clk = 1'b0;
  logic rstnn;
  logic init;
`ifdef DCA_ROW_LOADER_COLUMN_MODE_EN
  logic column_mode;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [BW_M-1:0] mat;
    int              cnt;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          nrows;
    bit          last;
    int          pat;
    int          base;
    bit          init_first;
    bit          reset_first;
    int          exp_count;
    logic [SC-1:0] pad;
  } vec_t;
  vec_t tbl[5];

  dca_matrix_row_loader_if #(.BW_ROW(BW_R), .BW_MATRIX(BW_M), .BW_COUNT(CW)) bus ();

  dca_matrix_row_loader #(
    .MATRIX_SIZE_PARA(ROWS),
    .BW_TENSOR_SCALAR(SC),
    .RESET_VALUE(RST_V),
    .INIT_VALUE(INIT_V)
  ) dut (
    .clk(clk),
    .rstnn(rstnn),
    .init(init),
`ifdef DCA_ROW_LOADER_COLUMN_MODE_EN
    .column_mode(column_mode),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_mat(input string name, input logic [BW_M-1:0] act, input logic [BW_M-1:0] req);
    for (int r = 0; r < ROWS; r++) begin
      total++;
      if (act[r*BW_R +: BW_R] !== req[r*BW_R +: BW_R]) begin
        bad++;
        $display("FAIL %s row%0d actual=%h required=%h", name, r,
                 act[r*BW_R +: BW_R], req[r*BW_R +: BW_R]);
      end
    end
  endtask

  // Element k,c of the stimulus: pattern 0 is base+16k+c, pattern 1 is 0x11*(k+1) in every column.
  function automatic logic [SC-1:0] pv(input int pat, input int base, input int k, input int c);
    if (pat == 0) return SC'(base + 16 * k + c);
    return SC'(32'h11 * (k + 1));
  endfunction

  function automatic logic [BW_R-1:0] row_vec(input int pat, input int base, input int k);
    logic [BW_R-1:0] v;
    for (int c = 0; c < ROWS; c++) v[c*SC +: SC] = pv(pat, base, k, c);
    return v;
  endfunction

  // Reference matrix: written rows (or columns) carry the pattern, the rest carry pad.
  function automatic logic [BW_M-1:0] exp_matrix(input int nrows, input int pat, input int base,
                                                 input logic [SC-1:0] pad, input bit col);
    logic [BW_M-1:0] m;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < ROWS; c++) begin
        if (!col) m[r*BW_R + c*SC +: SC] = (r < nrows) ? pv(pat, base, r, c) : pad;
        else      m[r*BW_R + c*SC +: SC] = (c < nrows) ? pv(pat, base, c, r) : pad;
      end
    end
    return m;
  endfunction

  task automatic feed_rows(input int nrows, input bit last, input int pat, input int base);
    for (int k = 0; k < nrows; k++) begin
      bus.row_valid = 1'b1;
      bus.row_data  = row_vec(pat, base, k);
      bus.row_last  = last && (k == nrows - 1);
      check32("row_ready_fill", 32'(bus.row_ready), 32'd1);
      check32("wenable_fill", 32'(bus.all_wenable), 32'd0);
      tick();
`ifdef DCA_ROW_LOADER_COLUMN_MODE_EN
      column_mode = 1'b0;
`endif
    end
    bus.row_valid = 1'b0;
    bus.row_last  = 1'b0;
  endtask

  // First cycle of a pending write: pop the scoreboard and compare.
  task automatic check_commit();
    exp_t e;
    check32("wenable_commit", 32'(bus.all_wenable), 32'd1);
    check32("row_ready_commit", 32'(bus.row_ready), 32'd0);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = exp_q.pop_front();
      check32("loaded_count_commit", 32'(bus.loaded_count), 32'(e.cnt));
      check_mat("commit_data", bus.all_wdata_list2d, e.mat);
    end
  endtask

  task automatic accept_commit();
    bus.commit_ready = 1'b1;
    tick();
    check32("wenable_after", 32'(bus.all_wenable), 32'd0);
    check32("row_ready_after", 32'(bus.row_ready), 32'd1);
    check32("count_after", 32'(bus.loaded_count), 32'd0);
    check_mat("cleared_after", bus.all_wdata_list2d, exp_matrix(0, 0, 0, INIT_V, 1'b0));
    bus.commit_ready = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [BW_M-1:0] m;

    tbl[0] = '{nrows:8, last:1'b0, pat:0, base:0,      init_first:1'b0, reset_first:1'b0, exp_count:8, pad:INIT_V};
    tbl[1] = '{nrows:3, last:1'b1, pat:1, base:0,      init_first:1'b1, reset_first:1'b0, exp_count:3, pad:INIT_V};
    tbl[2] = '{nrows:1, last:1'b1, pat:0, base:32'h100, init_first:1'b0, reset_first:1'b0, exp_count:1, pad:INIT_V};
    tbl[3] = '{nrows:8, last:1'b1, pat:0, base:32'h200, init_first:1'b0, reset_first:1'b0, exp_count:8, pad:INIT_V};
    tbl[4] = '{nrows:2, last:1'b1, pat:0, base:32'h300, init_first:1'b0, reset_first:1'b1, exp_count:2, pad:RST_V};

    rstnn = 1'b0;
    init  = 1'b0;
    bus.row_valid    = 1'b0;
    bus.row_data     = '0;
    bus.row_last     = 1'b0;
    bus.commit_ready = 1'b0;
`ifdef DCA_ROW_LOADER_COLUMN_MODE_EN
    column_mode = 1'b0;
`endif
    tick();
    tick();
    check32("reset_row_ready", 32'(bus.row_ready), 32'd1);
    check32("reset_wenable", 32'(bus.all_wenable), 32'd0);
    check32("reset_count", 32'(bus.loaded_count), 32'd0);
    check_mat("reset_data", bus.all_wdata_list2d, exp_matrix(0, 0, 0, RST_V, 1'b0));
    rstnn = 1'b1;

    // Table of load cases; commit_ready is high throughout, so FILL must ignore it.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].reset_first) begin
        rstnn = 1'b0;
        tick();
        rstnn = 1'b1;
      end
      if (tbl[i].init_first) begin
        init = 1'b1;
        tick();
        init = 1'b0;
        check32("init_count", 32'(bus.loaded_count), 32'd0);
      end
      bus.commit_ready = 1'b1;
      e.mat = exp_matrix(tbl[i].nrows, tbl[i].pat, tbl[i].base, tbl[i].pad, 1'b0);
      e.cnt = tbl[i].exp_count;
      exp_q.push_back(e);
      feed_rows(tbl[i].nrows, tbl[i].last, tbl[i].pat, tbl[i].base);
      check_commit();
      accept_commit();
    end

    // Backpressure: commit_ready low for the first 5 COMMIT cycles, row_valid held high.
    m = exp_matrix(8, 0, 32'h400, INIT_V, 1'b0);
    e.mat = m;
    e.cnt = 8;
    exp_q.push_back(e);
    feed_rows(8, 1'b0, 0, 32'h400);
    bus.row_valid = 1'b1;
    bus.row_data  = row_vec(0, 32'h500, 0);
    check_commit();
    for (int cyc = 2; cyc <= 6; cyc++) begin
      tick();
      check32("stall_wenable", 32'(bus.all_wenable), 32'd1);
      check32("stall_row_ready", 32'(bus.row_ready), 32'd0);
      check32("stall_count", 32'(bus.loaded_count), 32'd8);
      check_mat("stall_data", bus.all_wdata_list2d, m);
      if (cyc == 6) bus.commit_ready = 1'b1;
    end
    tick();
    bus.commit_ready = 1'b0;
    check32("bp_wenable_off", 32'(bus.all_wenable), 32'd0);
    check32("bp_no_early_row", 32'(bus.loaded_count), 32'd0);
    tick();
    check32("bp_row_taken", 32'(bus.loaded_count), 32'd1);
    bus.row_valid = 1'b0;
    init = 1'b1;
    tick();
    init = 1'b0;

    // Abort: init in the 2nd COMMIT cycle with commit_ready low.
    e.mat = exp_matrix(8, 0, 32'h600, INIT_V, 1'b0);
    e.cnt = 8;
    exp_q.push_back(e);
    feed_rows(8, 1'b0, 0, 32'h600);
    check_commit();
    tick();
    check32("abort_wenable_2nd", 32'(bus.all_wenable), 32'd1);
    init = 1'b1;
    tick();
    init = 1'b0;
    check32("abort_wenable", 32'(bus.all_wenable), 32'd0);
    check32("abort_row_ready", 32'(bus.row_ready), 32'd1);
    check32("abort_count", 32'(bus.loaded_count), 32'd0);
    check_mat("abort_data", bus.all_wdata_list2d, exp_matrix(0, 0, 0, INIT_V, 1'b0));

    // Reset after 4 rows, then a fresh full load.
    feed_rows(4, 1'b0, 0, 32'h700);
    check32("midfill_count", 32'(bus.loaded_count), 32'd4);
    rstnn = 1'b0;
    tick();
    rstnn = 1'b1;
    check32("rst_mid_count", 32'(bus.loaded_count), 32'd0);
    check32("rst_mid_wenable", 32'(bus.all_wenable), 32'd0);
    check_mat("rst_mid_data", bus.all_wdata_list2d, exp_matrix(0, 0, 0, RST_V, 1'b0));
    e.mat = exp_matrix(8, 0, 32'h800, RST_V, 1'b0);
    e.cnt = 8;
    exp_q.push_back(e);
    feed_rows(8, 1'b0, 0, 32'h800);
    check_commit();
    accept_commit();

`ifdef DCA_ROW_LOADER_COLUMN_MODE_EN
    // Column mode, latched on the first beat only (feed_rows drops column_mode after beat 0).
    column_mode = 1'b1;
    e.mat = exp_matrix(8, 0, 0, INIT_V, 1'b1);
    e.cnt = 8;
    exp_q.push_back(e);
    feed_rows(8, 1'b0, 0, 0);
    check_commit();
    accept_commit();
`endif

    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dca_matrix_row_loader.md
Name: dca_matrix_row_loader

Overview:
- Row-serial writer for the DCA matrix register family. It is the producer side of the `all_wenable`/`all_wdata_list2d` write interface.
- Accepts one matrix row per valid/ready beat and assembles rows in an internal buffer.
- Once a full matrix (or an early-terminated partial one) is assembled, presents it to the matrix register as a held write request until the downstream side accepts it.

Parameters:
- MATRIX_SIZE_PARA, 8: matrix geometry code, decoded by the team matrix-dim util into MATRIX_NUM_ROW/MATRIX_NUM_COL. Default decodes to 8x8.
- BW_TENSOR_SCALAR, 32: element width in bits.
- RESET_VALUE, 0: element value loaded into the buffer on reset.
- INIT_VALUE, RESET_VALUE: element value loaded on `init`, after each accepted commit, and used as pad value.
- Derived: BW_TENSOR_ROW = MATRIX_NUM_COL*BW_TENSOR_SCALAR; BW_TENSOR_MATRIX = MATRIX_NUM_ROW*BW_TENSOR_ROW.

Ports:
- clk  in  1  clock.
- rstnn  in  1  reset, synchronous, active-low.
- init  in  1  synchronous clear; priority over all other inputs except reset.
- row_valid  in  1  input row present.
- row_ready  out  1  loader can accept a row.
- row_data  in  BW_TENSOR_ROW  row payload; column c at bits [(c+1)*BW_TENSOR_SCALAR-1 : c*BW_TENSOR_SCALAR].
- row_last  in  1  qualifies row_data; this row terminates the matrix early.
- all_wenable  out  1  write request to the matrix register.
- all_wdata_list2d  out  BW_TENSOR_MATRIX  assembled matrix; row r at bits [(r+1)*BW_TENSOR_ROW-1 : r*BW_TENSOR_ROW]; row 0 is upmost.
- commit_ready  in  1  downstream accepts the write this cycle.
- loaded_count  out  $clog2(MATRIX_NUM_ROW+1)  rows captured in the current matrix.

Behaviour:
- Clock and reset: single clock `clk`; synchronous active-low reset `rstnn`.

Reset values:
- state = FILL; count = 0.
- Every buffer element = RESET_VALUE.
- row_ready = 1; all_wenable = 0; loaded_count = 0.

State FILL:
- row_ready = 1; all_wenable = 0.
- A transfer occurs when row_valid & row_ready.
- On transfer: buffer row[count] <= row_data; count <= count+1.
- If count == MATRIX_NUM_ROW-1 or row_last: go to COMMIT next cycle.
- row_last on row 0 gives a 1-row matrix.
- row_last on the final row behaves identically to a full matrix with no row_last.

State COMMIT:
- row_ready = 0; all_wenable = 1.
- all_wdata_list2d is held stable until accepted.
- On commit_ready:
  - all buffer elements <= INIT_VALUE;
  - count <= 0;
  - return to FILL (row_ready = 1 the next cycle).
- commit_ready is ignored in FILL.

Timing:
- Latency: the last row is accepted in cycle N; all_wenable = 1 in cycle N+1. With commit_ready tied to 1, all_wenable is a 1-cycle pulse and the next row is accepted in cycle N+2.
- all_wdata_list2d always drives the buffer register directly.
- In FILL it shows the partial matrix: unwritten rows read INIT_VALUE, or RESET_VALUE after reset before any commit or init.

Padding:
- On early termination, rows count..MATRIX_NUM_ROW-1 hold INIT_VALUE, because the buffer is cleared on every commit accept and on init.
- Exception: the very first matrix after reset pads with RESET_VALUE.

init (any state):
- buffer <= INIT_VALUE; count <= 0; state <= FILL; all_wenable <= 0 next cycle.
- A row offered in the same cycle as init is dropped.
- init during COMMIT aborts the pending write. The downstream side must tolerate all_wenable deasserting without commit_ready.

Other rules:
- row_data and row_last are sampled only on transfer.
- loaded_count = count; in COMMIT it equals the number of rows captured.

Optional Feature:
- Macro: DCA_ROW_LOADER_COLUMN_MODE_EN. Requires MATRIX_NUM_ROW == MATRIX_NUM_COL; an elaboration error otherwise.
- Enabled:
  - adds input port `column_mode` (1 bit), sampled on the first transfer of each matrix and held until the commit is accepted;
  - when latched 1, beat k is written to column k: element c of row_data goes to buffer row c, column k;
  - all other rules are unchanged, so early row_last pads the remaining columns.
- Disabled: no `column_mode` port; row-only loading.

Test Plan:
- Full load:
  - Stimulus: 8 rows, row r element c = 16*r+c, row_valid always 1, commit_ready = 1.
  - Response: all_wenable = 1 exactly one cycle after the 8th beat; element (r,c) = 16*r+c; loaded_count = 8; row_ready = 0 only during that cycle.
- Early last:
  - Stimulus: INIT_VALUE = 0xDEAD; init pulse; 3 rows of 0x11, 0x22, 0x33, row_last on the 3rd.
  - Response: rows 0-2 = 0x11/0x22/0x33; rows 3-7 = 0xDEAD; loaded_count = 3.
- Backpressure:
  - Stimulus: commit_ready low for 5 cycles after COMMIT entry; row_valid held high.
  - Response: all_wenable high 5+1 cycles; all_wdata_list2d stable throughout; no row accepted until the cycle after commit_ready.
- Abort:
  - Stimulus: init asserted in the 2nd COMMIT cycle with commit_ready = 0.
  - Response: next cycle all_wenable = 0, row_ready = 1, loaded_count = 0, all elements = INIT_VALUE.
- Reset mid-fill:
  - Stimulus: rstnn low after 4 rows accepted.
  - Response: next cycle count = 0, all elements = RESET_VALUE, all_wenable = 0; a fresh 8-row load then commits correctly.
- Column mode (macro on):
  - Stimulus: column_mode = 1; beat k element c = 16*k+c.
  - Response: element (r,c) = 16*c+r, i.e. the transpose of the full-load result.
